fifo_rd_arbiter: RTL and testbench
==================================

// Module: fifo_rd_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single read port of the async FIFO among N_REQ consumers.
//  Sits in the FIFO read-clock domain, between the read-pointer handler (empty/r_en) and the consumers.
//  Grants the port for bursts of up to MAX_BURST pops, then returns per-pop data tagged with the owner id.
// PARAMETERS
//  N_REQ      4  number of consumers (2..8)
//  DATA_WIDTH 8  FIFO data word width
//  MAX_BURST  4  max consecutive pops per grant (1..16)
// PORTS
//  clk       in   1           FIFO read clock; all logic on posedge
//  rst       in   1           asynchronous, active-low reset
//  req       in   N_REQ       level request per consumer; held while more words are wanted
//  empty     in   1           registered FIFO empty flag from read-pointer handler
//  rdata     in   DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop
//  r_en      out  1           pop strobe to FIFO
//  gnt       out  N_REQ       one-hot current owner; all-zero when idle
//  out_valid out  1           one-cycle pulse: out_data/out_id carry a popped word
//  out_data  out  DATA_WIDTH  popped word (registered copy of rdata)
//  out_id    out  clog2(N_REQ) index of consumer owning out_data
//  busy      out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, gnt=0, r_en=0, out_valid=0, out_data=0, out_id=0, busy=0, rr_ptr=0, burst_cnt=0.
//  FSM IDLE: if |req & !empty -> BURST; owner = first set req at or after rr_ptr (wrapping); gnt registered.
//  FSM BURST: r_en = req[owner] & !empty (combinational); each r_en cycle increments burst_cnt.
//   Exit to IDLE on the cycle when: burst_cnt reaches MAX_BURST with r_en, OR req[owner]=0, OR empty=1.
//   On exit: rr_ptr = owner+1 (mod N_REQ), burst_cnt=0, gnt=0. Grant gap of one IDLE cycle is required.
//  r_en is never asserted in IDLE and never asserted while empty=1 (no underflow).
//  Latency: r_en at cycle t -> out_valid, out_data=rdata, out_id=owner at cycle t+2 (one data, one output register).
//  Owner id is pipelined with the pop; a grant change never retags in-flight words.
//  Pops with out_valid pipeline full continue every cycle: sustained throughput 1 word/cycle within a burst.
//  Owner dropping req mid-burst: no further pops; in-flight words still delivered to that id.
//  empty rising mid-burst: burst ends that cycle; re-arbitration waits for !empty.
//  Single requester: after exit, rr_ptr advances but the same consumer wins again after one IDLE cycle.
//  Reset mid-burst: all state, pipeline and out_valid cleared immediately; in-flight words discarded.
//  rr_ptr wrap: N_REQ-1 +1 -> 0. burst_cnt width clog2(MAX_BURST+1).
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds output pop_cnt [N_REQ*16] (consumer i in bits [16i+15:16i]),
//   16-bit saturating count of pops granted per consumer, reset to 0, incremented on r_en for owner.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package fifo_arb_pkg: FSM state typedef (IDLE, BURST), ID_W = clog2(N_REQ) function, STATS_W=16 constant.
//  Sub-module rr_pick: combinational round-robin picker (req, rr_ptr -> one-hot pick, index, any).
//  Top holds FSM, burst counter, rr_ptr, two-stage data/id pipeline, optional stats counters.
// TESTING
//  Reset: rst=0 with req=4'b1111, empty=0 -> gnt=0, r_en=0, out_valid=0 throughout; rr_ptr=0 on release.
//  Fairness: req=4'b1111, empty=0, MAX_BURST=4 -> grants 0,1,2,3,0 in order, each exactly 4 pops, 1 idle cycle between.
//  Latency/tagging: req=4'b0100, FIFO words A,B -> out_valid two cycles after each r_en, out_data=A,B, out_id=2.
//  Empty: 2 words in FIFO, req[1] held -> 2 pops, burst ends on empty=1, r_en never high while empty=1.
//  Early drop: req[3] drops after 1 pop -> burst ends, rr_ptr=0, next grant to req[0] if pending.
//  Stats (FIFO_ARB_STATS_EN): 10 pops to consumer 1 -> pop_cnt[31:16]=10, others 0; saturates at 16'hFFFF.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO read-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of each per-consumer pop statistics counter
  localparam int unsigned STATS_W = 16;

  // Width of a consumer index; never narrower than one bit
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] pick,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W:0] cand;

  // Scan from ptr upward with modulo-N_REQ wrap; first hit wins
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!any && req[cand[ID_W-1:0]]) begin
        any                    = 1'b1;
        idx                    = cand[ID_W-1:0];
        pick[cand[ID_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among N_REQ consumers.
// Grants bursts of up to MAX_BURST pops; popped words come out two cycles
// after their pop, tagged with the owner id captured at pop time.
// Optional feature: define FIFO_ARB_STATS_EN to add per-consumer pop counters.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_W       = id_w(N_REQ),
  localparam int unsigned BC_W       = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  r_en,
  output logic [N_REQ-1:0]      gnt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STATS_W-1:0] pop_cnt
`endif
);

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_ptr_nxt;
  logic [BC_W-1:0] burst_cnt;
  logic            exit_c;
  logic [N_REQ-1:0] pick_c;
  logic [ID_W-1:0]  pick_idx_c;
  logic             pick_any_c;
  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick_c),
    .idx  (pick_idx_c),
    .any  (pick_any_c)
  );

  // Burst ends on the last allowed pop, on owner release, or when the FIFO drains
  assign exit_c = !req[owner] || empty ||
                  (r_en && (burst_cnt == BC_W'(MAX_BURST - 1)));

  // Pointer moves just past the outgoing owner
  assign rr_ptr_nxt = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any_c && !empty) state_nxt = ST_BURST;
      ST_BURST: if (exit_c)               state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM output: pop only for a granted, still-requesting owner with data present
  always_comb begin
    r_en = 1'b0;
    if (state == ST_BURST) r_en = req[owner] && !empty;
  end

  // Grant, owner, round-robin pointer and burst counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      if (state == ST_IDLE && state_nxt == ST_BURST) begin
        gnt   <= pick_c;
        owner <= pick_idx_c;
      end else if (state == ST_BURST && state_nxt == ST_IDLE) begin
        gnt       <= '0;
        rr_ptr    <= rr_ptr_nxt;
        burst_cnt <= '0;
      end else if (r_en) begin
        burst_cnt <= burst_cnt + BC_W'(1);
      end
    end
  end

  // Two-stage pop pipeline: id rides with the pop, data is captured when the FIFO presents it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      s1_valid  <= r_en;
      s1_id     <= owner;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= rdata;
        out_id   <= s1_id;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating per-consumer pop counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (r_en && owner == ID_W'(i) && pop_cnt[STATS_W*i +: STATS_W] != '1)
          pop_cnt[STATS_W*i +: STATS_W] <= pop_cnt[STATS_W*i +: STATS_W] + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed self-checking bench for fifo_rd_arbiter (N_REQ=4, MAX_BURST=4).
// Includes a small FIFO read-side model: registered empty flag, rdata the cycle after a pop.
// Stats checks are compiled when FIFO_ARB_STATS_EN is defined.
module tb_fifo_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       r_en;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_id;
  logic       busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] pop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] fifo_q[$];

  fifo_rd_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .empty     (empty),
    .rdata     (rdata),
    .r_en      (r_en),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .pop_cnt   (pop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIFO read-side model
  always @(posedge clk) begin
    if (r_en && fifo_q.size() > 0) rdata <= fifo_q.pop_front();
    empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
  endtask

  // Wait (bounded) at negedges for the next pop strobe
  task automatic wait_ren(input string tag);
    int n = 0;
    while (!r_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(r_en), 32'd1);
  endtask

  // Pops must never happen while empty or outside a burst
  always @(negedge clk) begin
    if (rst && r_en) begin
      check("no_underflow", 32'(empty), 32'd0);
      check("ren_in_burst", 32'(busy), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_gnt;
    rst = 1'b0;
    req = 4'b1111;
    push_words(24, 8'h40);

    // Reset held with pending requests and data
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt",  32'(gnt),       32'd0);
      check("rst_ren",  32'(r_en),      32'd0);
      check("rst_oval", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy),      32'd0);
      check("rst_oid",  32'(out_id),    32'd0);
    end

    // Fairness: 0,1,2,3 each 4 pops with one idle cycle between
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_gnt = 4'b0001 << g;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("fair_gnt", 32'(gnt),  32'(exp_gnt));
        check("fair_ren", 32'(r_en), 32'd1);
      end
      @(negedge clk);
      check("gap_gnt",  32'(gnt),  32'd0);
      check("gap_ren",  32'(r_en), 32'd0);
      check("gap_busy", 32'(busy), 32'd0);
    end
    // Wrap back to consumer 0; last word of consumer 3 still tagged 3
    @(negedge clk);
    check("wrap_gnt",   32'(gnt),       32'h1);
    check("tag3_valid", 32'(out_valid), 32'd1);
    check("tag3_id",    32'(out_id),    32'd3);
    check("tag3_data",  32'(out_data),  32'h4F);
    @(negedge clk);
    @(negedge clk);
    check("tag0_valid", 32'(out_valid), 32'd1);
    check("tag0_id",    32'(out_id),    32'd0);
    check("tag0_data",  32'(out_data),  32'h50);
    check("tag0_ren",   32'(r_en),      32'd1);

    // Reset mid-burst clears everything immediately
    rst = 1'b0;
    #1;
    check("mrst_oval",  32'(out_valid), 32'd0);
    check("mrst_ren",   32'(r_en),      32'd0);
    check("mrst_gnt",   32'(gnt),       32'd0);
    check("mrst_busy",  32'(busy),      32'd0);
    check("mrst_odata", 32'(out_data),  32'd0);

    // Latency and tagging: consumer 2 pops A5, 3C
    @(negedge clk);
    fifo_q.delete();
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    rst = 1'b1;
    wait_ren("lat");
    check("lat_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    check("lat_ren2", 32'(r_en), 32'd1);
    @(negedge clk);
    check("lat_ovA",  32'(out_valid), 32'd1);
    check("lat_dA",   32'(out_data),  32'hA5);
    check("lat_idA",  32'(out_id),    32'd2);
    check("lat_ren3", 32'(r_en),      32'd0);
    @(negedge clk);
    check("lat_ovB",  32'(out_valid), 32'd1);
    check("lat_dB",   32'(out_data),  32'h3C);
    check("lat_idB",  32'(out_id),    32'd2);
    check("lat_busy", 32'(busy),      32'd0);
    @(negedge clk);
    check("lat_ov_end", 32'(out_valid), 32'd0);

    // Empty ends the burst after the two available words
    req = 4'b0010;
    push_words(2, 8'h60);
    wait_ren("emp");
    check("emp_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    check("emp_ren2", 32'(r_en), 32'd1);
    @(negedge clk);
    check("emp_ren3", 32'(r_en), 32'd0);
    check("emp_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("emp_exit_busy", 32'(busy), 32'd0);
    check("emp_exit_gnt",  32'(gnt),  32'd0);
    @(negedge clk);
    check("emp_wait_ren", 32'(r_en), 32'd0);

    // Single requester wins again after one idle cycle
    push_words(6, 8'h70);
    wait_ren("single");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("single_ren", 32'(r_en), 32'd1);
      check("single_gnt", 32'(gnt),  32'h2);
    end
    @(negedge clk);
    check("single_gap_gnt", 32'(gnt),  32'd0);
    check("single_gap_ren", 32'(r_en), 32'd0);
    @(negedge clk);
    check("single_regnt", 32'(gnt),  32'h2);
    check("single_reren", 32'(r_en), 32'd1);
    @(negedge clk);
    check("single_ren6", 32'(r_en), 32'd1);
    @(negedge clk);
    check("single_drain", 32'(r_en), 32'd0);

    // Early drop: consumer 3 pops once, releases; pointer wraps to 0
    rst = 1'b0;
    @(negedge clk);
    fifo_q.delete();
    push_words(10, 8'h80);
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_ren("drop");
    check("drop_gnt", 32'(gnt), 32'h8);
    @(negedge clk);
    req = 4'b0101;
    #1;
    check("drop_ren", 32'(r_en), 32'd0);
    @(negedge clk);
    check("drop_ov",   32'(out_valid), 32'd1);
    check("drop_id",   32'(out_id),    32'd3);
    check("drop_data", 32'(out_data),  32'h80);
    check("drop_gnt0", 32'(gnt),       32'd0);
    @(negedge clk);
    check("drop_next_gnt", 32'(gnt),  32'h1);
    check("drop_next_ren", 32'(r_en), 32'd1);

`ifdef FIFO_ARB_STATS_EN
    // Ten pops all to consumer 1
    rst = 1'b0;
    @(negedge clk);
    fifo_q.delete();
    push_words(10, 8'h90);
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("stats_c0", 32'(pop_cnt[15:0]),  32'd0);
    check("stats_c1", 32'(pop_cnt[31:16]), 32'd10);
    check("stats_c2", 32'(pop_cnt[47:32]), 32'd0);
    check("stats_c3", 32'(pop_cnt[63:48]), 32'd0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
